branch_resolve_cycle: RTL and testbench
=======================================

# branch_resolve_cycle

Decode-to-execute stage block that consumes the fetch stage's `InstrD`/`PCD`/`PCPlus4D` and closes the loop by driving `PCSrcE`/`PCTargetE` back into fetch. It registers control-flow instructions into E, resolves conditional branches, JAL and JALR, and issues a one-cycle redirect. It squashes the wrong-path instructions already in flight, because fetch has no flush input. It also keeps branch statistics counters.

## Interface
Parameters:
- `SHADOW_SLOTS`, default 2: wrong-path instructions squashed after each redirect. Legal range 1..3.
- `CNT_WIDTH`, default 32: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `InstrD` in 32: instruction from the fetch register.
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: `PCD+4`.
- `RD1D` in 32: rs1 value, already forwarded.
- `RD2D` in 32: rs2 value, already forwarded.
- `PCSrcE` out 1: redirect fetch this cycle.
- `PCTargetE` out 32: redirect target.
- `ValidE` out 1: E holds a live instruction.
- `LinkWriteE` out 1: live JAL/JALR with rd≠0.
- `RdE` out 5: link destination register.
- `LinkDataE` out 32: `PCPlus4E`.
- `MisalignE` out 1: a taken target has `[1:0]≠0`.
- `BranchCnt` out CNT_WIDTH: live control-flow instructions resolved.
- `TakenCnt` out CNT_WIDTH: redirects issued.

## Operation
- **E register** captures `InstrD`, `PCD`, `PCPlus4D`, `RD1D`, `RD2D` on every edge. `ValidE` is loaded with 0 if any of these hold:
  - `InstrD==0` (fetch reset bubble);
  - `PCSrcE==1` this cycle;
  - `SquashCnt≠0`.
  Otherwise `ValidE` is loaded with 1.
- **Decode** on `InstrE[6:0]`; all other opcodes are non-control.
  - `1100011` branch. funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned). funct3 010/011 are never taken.
  - `1101111` JAL: always taken. Target = `PCE + J-imm`.
  - `1100111` with funct3 000 JALR: always taken. Target = `(RD1E + I-imm) & ~1`.
  - Branch target = `PCE + B-imm`.
  - Immediates are sign-extended to 32 bits. All adds are modulo 2^32; wrap-around is allowed.
- **Redirect outputs**:
  - `taken` = `ValidE` & control instruction & condition true.
  - `MisalignE` = `taken & (target[1:0]≠0)`.
  - `PCSrcE` = `taken & ~MisalignE`.
  - `PCTargetE` = target whenever `ValidE` holds a control instruction, else 0.
- **Squash FSM**, states RUN and SHADOW, counter `SquashCnt` of 2 bits:
  - RUN → SHADOW on an edge with `PCSrcE==1`. Set `SquashCnt` = `SHADOW_SLOTS-1`; if `SHADOW_SLOTS==1`, stay in RUN.
  - In SHADOW, each edge decrements `SquashCnt`. The transition to RUN happens when `SquashCnt` reaches 0.
  - A squashed instruction can never redirect, link, or count.
- **Link outputs**:
  - `LinkWriteE` = `ValidE` & (JAL|JALR) & `RdE≠0`. It is asserted even when `MisalignE` is set.
  - `LinkDataE` = `PCPlus4E`.
- **Counters**:
  - `BranchCnt` increments per valid control instruction in E.
  - `TakenCnt` increments per `PCSrcE`.
  - Both wrap modulo 2^CNT_WIDTH.
  - `MisalignE` increments `BranchCnt` only.

## Timing
- **Reset**: with `rst==0` at an edge, all E registers, `ValidE`, `SquashCnt` and both counters are set to 0 and the FSM goes to RUN. All outputs read 0 the cycle after.
  - Reset has priority over an in-progress shadow; no squash persists past reset.
- **Latency**: one cycle from `InstrD` to E.
  - `PCSrcE`/`PCTargetE` are combinational from E state and valid in the same cycle.
  - Fetch loads the PC at the following edge.
- **Redirect pulse**: `PCSrcE` is high for exactly one cycle per taken instruction. Two redirects are never closer than `SHADOW_SLOTS+1` cycles.
- **Default shadow** (`SHADOW_SLOTS=2`): with a branch in E during cycle t, the instructions at branch+4 and branch+8 enter E in cycles t+1 and t+2 with `ValidE=0`. The target instruction enters E in cycle t+3 with `ValidE=1`.
- **Simultaneous events**: `PCSrcE` and `SquashCnt≠0` cannot coexist, because shadow instructions are invalid.

## Test plan
- **Taken BEQ**: `RD1D=RD2D=5`, `PCD=0x100`, B-imm=+0x20.
  - Cycle E: `PCSrcE=1`, `PCTargetE=0x120`.
  - The next 2 E cycles have `ValidE=0`.
  - `TakenCnt`=1, `BranchCnt`=1.
- **BLT vs BLTU**: rs1=0xFFFFFFFF, rs2=1.
  - BLT is taken.
  - BLTU is not taken: `PCSrcE=0`, `ValidE` stays high for following instructions.
- **JALR**: rd=1, `RD1D=0x203`, imm=+0x10, `PCD=0x40`.
  - `PCTargetE=0x212`, `MisalignE=1`, `PCSrcE=0`, `LinkWriteE=1`, `LinkDataE=0x44`.
- **Wrong-path suppression**: a taken branch is followed by two taken branches in the shadow.
  - Exactly one `PCSrcE` pulse; `TakenCnt` advances by 1.
- **Reset mid-shadow**: assert `rst=0` one cycle after `PCSrcE`.
  - All outputs are 0 and the FSM is in RUN.
  - The first nonzero `InstrD` after release gives `ValidE=1`.
- **Wrap-around**: JAL at `PCD=0xFFFFFFF0` with J-imm=+0x20 gives `PCTargetE=0x00000010`. With `CNT_WIDTH=4`, 16 taken branches return `TakenCnt` to 0.

Source files
------------

// File: rtl/branch_resolve_cycle_if.sv
// branch_resolve_cycle_if: decode-to-execute bus between fetch/decode and the branch resolve stage.
//   Decode side (driven by fetch/decode): InstrD, PCD, PCPlus4D, RD1D, RD2D
//   Execute side (driven by the stage):    PCSrcE, PCTargetE, ValidE, LinkWriteE, RdE,
//                                          LinkDataE, MisalignE, BranchCnt, TakenCnt
//   Modports: slave = the resolve stage, master = the fetch/decode side.
interface branch_resolve_cycle_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          InstrD;
    logic [31:0]          PCD;
    logic [31:0]          PCPlus4D;
    logic [31:0]          RD1D;
    logic [31:0]          RD2D;
    logic                 PCSrcE;
    logic [31:0]          PCTargetE;
    logic                 ValidE;
    logic                 LinkWriteE;
    logic [4:0]           RdE;
    logic [31:0]          LinkDataE;
    logic                 MisalignE;
    logic [CNT_WIDTH-1:0] BranchCnt;
    logic [CNT_WIDTH-1:0] TakenCnt;

    modport slave (
        input  InstrD, PCD, PCPlus4D, RD1D, RD2D,
        output PCSrcE, PCTargetE, ValidE, LinkWriteE, RdE, LinkDataE, MisalignE,
               BranchCnt, TakenCnt
    );

    modport master (
        output InstrD, PCD, PCPlus4D, RD1D, RD2D,
        input  PCSrcE, PCTargetE, ValidE, LinkWriteE, RdE, LinkDataE, MisalignE,
               BranchCnt, TakenCnt
    );
endinterface

// File: rtl/branch_resolve_cycle.sv
// branch_resolve_cycle: E-stage control-flow resolver with redirect, wrong-path squash and branch statistics.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-low reset
//   bus  : branch_resolve_cycle_if.slave
//          in  InstrD/PCD/PCPlus4D/RD1D/RD2D from decode
//          out PCSrcE/PCTargetE redirect to fetch, ValidE, link outputs, MisalignE, counters
module branch_resolve_cycle #(
    parameter int SHADOW_SLOTS = 2,
    parameter int CNT_WIDTH    = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_cycle_if.slave bus
);
    typedef enum logic {RUN, SHADOW} state_t;

    state_t               state, state_next;
    logic [1:0]           squash_cnt, squash_next;
    logic [31:0]          instr_e, pc_e, pc4_e, rd1_e, rd2_e;
    logic                 valid_e;
    logic [CNT_WIDTH-1:0] branch_cnt, taken_cnt;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_b, imm_j, imm_i, target;
    logic        is_br, is_jal, is_jalr, is_ctrl, is_link;
    logic        eq, slt, ult, cond, taken, misalign, pc_src;

    assign opcode = instr_e[6:0];
    assign funct3 = instr_e[14:12];
    assign imm_b  = {{20{instr_e[31]}}, instr_e[7], instr_e[30:25], instr_e[11:8], 1'b0};
    assign imm_j  = {{12{instr_e[31]}}, instr_e[19:12], instr_e[20], instr_e[30:21], 1'b0};
    assign imm_i  = {{20{instr_e[31]}}, instr_e[31:20]};

    assign is_br   = opcode == 7'b1100011;
    assign is_jal  = opcode == 7'b1101111;
    assign is_jalr = opcode == 7'b1100111 && funct3 == 3'b000;
    assign is_link = is_jal | is_jalr;
    assign is_ctrl = is_br | is_link;

    assign eq  = rd1_e == rd2_e;
    assign slt = $signed(rd1_e) < $signed(rd2_e);
    assign ult = rd1_e < rd2_e;
    // funct3[2:1] picks the comparison, funct3[0] inverts it; 01x has no comparison and is never taken
    assign cond = (funct3[2:1] == 2'b01) ? 1'b0 : ((funct3[2] ? (funct3[1] ? ult : slt) : eq) ^ funct3[0]);

    assign target   = is_jalr ? ((rd1_e + imm_i) & ~32'd1) : pc_e + (is_jal ? imm_j : imm_b);
    assign taken    = valid_e & (is_link | (is_br & cond));
    assign misalign = taken & (target[1:0] != 2'b00);
    assign pc_src   = taken & ~misalign;

    assign bus.PCSrcE     = pc_src;
    assign bus.PCTargetE  = (valid_e & is_ctrl) ? target : 32'd0;
    assign bus.ValidE     = valid_e;
    assign bus.MisalignE  = misalign;
    assign bus.LinkWriteE = valid_e & is_link & (instr_e[11:7] != 5'd0);
    assign bus.RdE        = instr_e[11:7];
    assign bus.LinkDataE  = pc4_e;
    assign bus.BranchCnt  = branch_cnt;
    assign bus.TakenCnt   = taken_cnt;

    // Squash count covers the shadow slots after the redirect edge itself, which already loads an invalid slot
    always_comb begin
        state_next  = state;
        squash_next = squash_cnt;
        if (state == RUN) begin
            if (pc_src) begin
                squash_next = 2'(SHADOW_SLOTS - 1);
                if (SHADOW_SLOTS > 1)
                    state_next = SHADOW;
            end
        end else begin
            squash_next = squash_cnt - 2'd1;
            if (squash_cnt == 2'd1)
                state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            squash_cnt <= 2'd0;
            instr_e    <= 32'd0;
            pc_e       <= 32'd0;
            pc4_e      <= 32'd0;
            rd1_e      <= 32'd0;
            rd2_e      <= 32'd0;
            valid_e    <= 1'b0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            state      <= state_next;
            squash_cnt <= squash_next;
            instr_e    <= bus.InstrD;
            pc_e       <= bus.PCD;
            pc4_e      <= bus.PCPlus4D;
            rd1_e      <= bus.RD1D;
            rd2_e      <= bus.RD2D;
            valid_e    <= (bus.InstrD != 32'd0) && !pc_src && (squash_cnt == 2'd0);
            branch_cnt <= branch_cnt + CNT_WIDTH'(valid_e & is_ctrl);
            taken_cnt  <= taken_cnt + CNT_WIDTH'(pc_src);
        end
    end
endmodule

// File: tb/tb_branch_resolve_cycle.sv
// tb_branch_resolve_cycle: directed-vector bench for branch_resolve_cycle (default and 4-bit-counter instances).
module tb_branch_resolve_cycle;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    branch_resolve_cycle_if #(.CNT_WIDTH(32)) bus ();
    branch_resolve_cycle_if #(.CNT_WIDTH(4))  sbus ();

    branch_resolve_cycle #(.SHADOW_SLOTS(2), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    branch_resolve_cycle #(.SHADOW_SLOTS(2), .CNT_WIDTH(4))  dut_s (.clk(clk), .rst(rst), .bus(sbus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, rd, 7'b1100111};
    endfunction

    // drive both instances identically, advance one edge, sample 1 time unit later
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        bus.InstrD = instr;  bus.PCD = pc;  bus.PCPlus4D = pc + 32'd4;  bus.RD1D = a;  bus.RD2D = b;
        sbus.InstrD = instr; sbus.PCD = pc; sbus.PCPlus4D = pc + 32'd4; sbus.RD1D = a; sbus.RD2D = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with live-looking inputs: everything must still read 0
        step(enc_b(3'b000, 13'h020), 32'h100, 32'd5, 32'd5);
        step(enc_b(3'b000, 13'h020), 32'h100, 32'd5, 32'd5);
        check("rst_valid", {31'd0, bus.ValidE}, 32'd0);
        check("rst_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
        check("rst_target", bus.PCTargetE, 32'd0);
        check("rst_linkdata", bus.LinkDataE, 32'd0);
        check("rst_linkwrite", {31'd0, bus.LinkWriteE}, 32'd0);
        check("rst_branchcnt", bus.BranchCnt, 32'd0);
        check("rst_takencnt", bus.TakenCnt, 32'd0);
        rst = 1'b1;

        step(NOP, 32'hFC, 32'd0, 32'd0);
        check("nop_valid", {31'd0, bus.ValidE}, 32'd1);
        check("nop_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);

        // taken BEQ
        step(enc_b(3'b000, 13'h020), 32'h100, 32'd5, 32'd5);
        check("beq_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        check("beq_target", bus.PCTargetE, 32'h120);
        step(NOP, 32'h104, 32'd0, 32'd0);
        check("beq_shadow1_valid", {31'd0, bus.ValidE}, 32'd0);
        check("beq_takencnt", bus.TakenCnt, 32'd1);
        check("beq_branchcnt", bus.BranchCnt, 32'd1);
        step(NOP, 32'h108, 32'd0, 32'd0);
        check("beq_shadow2_valid", {31'd0, bus.ValidE}, 32'd0);
        step(NOP, 32'h120, 32'd0, 32'd0);
        check("beq_target_valid", {31'd0, bus.ValidE}, 32'd1);

        // BLT taken, BLTU not taken on -1 vs 1
        step(enc_b(3'b100, 13'h040), 32'h200, 32'hFFFF_FFFF, 32'd1);
        check("blt_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        check("blt_target", bus.PCTargetE, 32'h240);
        step(NOP, 32'h204, 32'd0, 32'd0);
        step(NOP, 32'h208, 32'd0, 32'd0);
        step(enc_b(3'b110, 13'h040), 32'h240, 32'hFFFF_FFFF, 32'd1);
        check("bltu_valid", {31'd0, bus.ValidE}, 32'd1);
        check("bltu_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
        check("bltu_target", bus.PCTargetE, 32'h280);
        step(NOP, 32'h244, 32'd0, 32'd0);
        check("bltu_next_valid", {31'd0, bus.ValidE}, 32'd1);
        check("bltu_branchcnt", bus.BranchCnt, 32'd3);
        check("bltu_takencnt", bus.TakenCnt, 32'd2);

        // misaligned JALR still links, no redirect
        step(enc_jalr(5'd1, 12'h010), 32'h40, 32'h203, 32'd0);
        check("jalr_target", bus.PCTargetE, 32'h212);
        check("jalr_misalign", {31'd0, bus.MisalignE}, 32'd1);
        check("jalr_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
        check("jalr_linkwrite", {31'd0, bus.LinkWriteE}, 32'd1);
        check("jalr_linkdata", bus.LinkDataE, 32'h44);
        check("jalr_rd", {27'd0, bus.RdE}, 32'd1);
        step(NOP, 32'h44, 32'd0, 32'd0);
        check("jalr_next_valid", {31'd0, bus.ValidE}, 32'd1);
        check("jalr_branchcnt", bus.BranchCnt, 32'd4);
        check("jalr_takencnt", bus.TakenCnt, 32'd2);

        // taken branch followed by two would-be-taken branches in the shadow
        step(enc_b(3'b000, 13'h020), 32'h300, 32'd5, 32'd5);
        check("wp_pcsrc0", {31'd0, bus.PCSrcE}, 32'd1);
        step(enc_b(3'b000, 13'h020), 32'h304, 32'd5, 32'd5);
        check("wp_pcsrc1", {31'd0, bus.PCSrcE}, 32'd0);
        check("wp_target1", bus.PCTargetE, 32'd0);
        step(enc_b(3'b000, 13'h020), 32'h308, 32'd5, 32'd5);
        check("wp_pcsrc2", {31'd0, bus.PCSrcE}, 32'd0);
        step(NOP, 32'h320, 32'd0, 32'd0);
        check("wp_target_valid", {31'd0, bus.ValidE}, 32'd1);
        check("wp_takencnt", bus.TakenCnt, 32'd3);
        check("wp_branchcnt", bus.BranchCnt, 32'd5);

        // JAL target wraps around 2^32; rd=0 does not link
        step(enc_jal(5'd0, 21'h00020), 32'hFFFF_FFF0, 32'd0, 32'd0);
        check("jal_target", bus.PCTargetE, 32'h10);
        check("jal_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        check("jal_linkwrite", {31'd0, bus.LinkWriteE}, 32'd0);
        step(NOP, 32'hFFFF_FFF4, 32'd0, 32'd0);
        step(NOP, 32'hFFFF_FFF8, 32'd0, 32'd0);
        step(NOP, 32'h10, 32'd0, 32'd0);
        check("jal_takencnt", bus.TakenCnt, 32'd4);
        check("small_takencnt", {28'd0, sbus.TakenCnt}, 32'd4);

        // reset one cycle after a redirect clears the shadow
        step(enc_b(3'b001, 13'h020), 32'h400, 32'd1, 32'd2);
        check("bne_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        rst = 1'b0;
        step(NOP, 32'h404, 32'd0, 32'd0);
        check("midrst_valid", {31'd0, bus.ValidE}, 32'd0);
        check("midrst_target", bus.PCTargetE, 32'd0);
        check("midrst_linkdata", bus.LinkDataE, 32'd0);
        check("midrst_takencnt", bus.TakenCnt, 32'd0);
        check("midrst_branchcnt", bus.BranchCnt, 32'd0);
        rst = 1'b1;
        step(NOP, 32'h420, 32'd0, 32'd0);
        check("postrst_valid", {31'd0, bus.ValidE}, 32'd1);

        // 16 taken branches wrap the 4-bit counters to 0
        for (int i = 0; i < 16; i++) begin
            step(enc_b(3'b101, 13'h020), 32'h500, 32'd7, 32'd3);
            step(NOP, 32'h504, 32'd0, 32'd0);
            step(NOP, 32'h508, 32'd0, 32'd0);
        end
        check("wrap_small_takencnt", {28'd0, sbus.TakenCnt}, 32'd0);
        check("wrap_small_branchcnt", {28'd0, sbus.BranchCnt}, 32'd0);
        check("wrap_takencnt", bus.TakenCnt, 32'd16);
        check("wrap_branchcnt", bus.BranchCnt, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
